// File: rtl/uart_rx_8n1.sv
// UART 8N1 receiver: 2-flop input synchronizer, mid-bit sampling from an internal baud
// counter, and a holding register with valid/ack handshake, framing-error and overrun status.
module uart_rx_8n1 #(
    parameter int CLKS_PER_BIT = 1250,
    parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
    input  logic       hwclk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rxbyte,
    output logic       rxvalid,
    input  logic       rxack,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LP_BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] LP_HALF_LAST = CW'(HALF_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    logic          r_rx_meta;
    logic          r_rx_s;
    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_bit_idx;
    logic [7:0]    r_shift;
    logic [7:0]    r_rxbyte;
    logic          r_rxvalid;
    logic          r_frame_err;
    logic          r_overrun;

    state_t        w_state_next;
    logic [CW-1:0] w_cnt_next;
    logic [2:0]    w_bit_idx_next;
    logic [7:0]    w_shift_next;
    logic          w_deliver;
    logic          w_frame_err;

    // NOTE: synchronizer resets to the idle line level so reset release never looks like a start bit.
    always_ff @(posedge hwclk or posedge rst) begin
        if (rst) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_s    <= r_rx_meta;
        end
    end

    always_ff @(posedge hwclk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
        end else begin
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
            r_bit_idx <= w_bit_idx_next;
            r_shift   <= w_shift_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_next   = r_state;
        w_cnt_next     = r_cnt;
        w_bit_idx_next = r_bit_idx;
        w_shift_next   = r_shift;
        w_deliver      = 1'b0;
        w_frame_err    = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (!r_rx_s) begin
                    w_state_next = S_START;
                    w_cnt_next   = '0;
                end
            end
            S_START: begin
                if (r_cnt == LP_HALF_LAST) begin
                    w_cnt_next     = '0;
                    w_bit_idx_next = '0;
                    w_state_next   = r_rx_s ? S_IDLE : S_DATA;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            S_DATA: begin
                if (r_cnt == LP_BIT_LAST) begin
                    w_cnt_next     = '0;
                    w_shift_next   = {r_rx_s, r_shift[7:1]};
                    w_bit_idx_next = r_bit_idx + 1'b1;
                    if (r_bit_idx == 3'd7) begin
                        w_state_next = S_STOP;
                    end
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            S_STOP: begin
                if (r_cnt == LP_BIT_LAST) begin
                    w_cnt_next = '0;
                    if (r_rx_s) begin
                        w_deliver    = 1'b1;
                        w_state_next = S_IDLE;
                    end else begin
                        w_frame_err  = 1'b1;
                        w_state_next = S_BREAK;
                    end
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            S_BREAK: begin
                if (r_rx_s) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // A delivery that meets a same-cycle ack replaces the pending byte instead of overrunning.
    always_ff @(posedge hwclk or posedge rst) begin
        if (rst) begin
            r_rxbyte    <= '0;
            r_rxvalid   <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_frame_err <= w_frame_err;
            if (w_deliver) begin
                if (!r_rxvalid || rxack) begin
                    r_rxbyte  <= r_shift;
                    r_rxvalid <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_rxvalid && rxack) begin
                r_rxvalid <= 1'b0;
            end
        end
    end

    assign rxbyte    = r_rxbyte;
    assign rxvalid   = r_rxvalid;
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;
    assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_8n1.sv
// Bench for uart_rx_8n1: frames are scheduled as timed events (delivery, frame error, busy window)
// derived from the bit-timing rules, replayed by a cycle model and compared on every cycle.
module tb_uart_rx_8n1;

    localparam int C1  = 16;
    localparam int C2  = 1250;
    localparam int BIG = 32'h7fffffff;

    logic       hwclk  = 1'b0;
    logic       rst    = 1'b1;
    logic       rx1    = 1'b1;
    logic       rx2    = 1'b1;
    logic       rxack  = 1'b0;
    logic       rxack2 = 1'b0;
    logic [7:0] rxbyte,    rxbyte2;
    logic       rxvalid,   rxvalid2;
    logic       frame_err, frame_err2;
    logic       overrun,   overrun2;
    logic       busy,      busy2;

    uart_rx_8n1 #(.CLKS_PER_BIT(C1)) dut (
        .hwclk(hwclk), .rst(rst), .rx(rx1), .rxbyte(rxbyte), .rxvalid(rxvalid),
        .rxack(rxack), .frame_err(frame_err), .overrun(overrun), .busy(busy)
    );

    uart_rx_8n1 #(.CLKS_PER_BIT(C2)) dut_slow (
        .hwclk(hwclk), .rst(rst), .rx(rx2), .rxbyte(rxbyte2), .rxvalid(rxvalid2),
        .rxack(rxack2), .frame_err(frame_err2), .overrun(overrun2), .busy(busy2)
    );

    initial forever #5 hwclk = ~hwclk;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // Event schedule, written by the stimulus
    int         d_cyc  [64];
    logic [7:0] d_byte [64];
    int         d_wr = 0;
    int         f_cyc  [64];
    int         f_wr = 0;
    int         b_lo   [64];
    int         b_hi   [64];
    int         b_n  = 0;

    // Model state, written by the model process
    int         d_rd    = 0;
    int         f_rd    = 0;
    logic       m_valid = 1'b0;
    logic [7:0] m_byte  = 8'h00;
    logic       m_ovr   = 1'b0;
    logic       m_ferr  = 1'b0;
    logic       m_busy;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            if (n_err <= 40)
                $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    initial forever begin
        @(posedge hwclk);
        cyc++;
        if (rst) begin
            m_valid = 1'b0;
            m_byte  = 8'h00;
            m_ovr   = 1'b0;
            m_ferr  = 1'b0;
            d_rd    = d_wr;
            f_rd    = f_wr;
        end else begin
            m_ferr = 1'b0;
            if (f_rd != f_wr && f_cyc[f_rd] == cyc) begin
                m_ferr = 1'b1;
                f_rd++;
            end
            if (d_rd != d_wr && d_cyc[d_rd] == cyc) begin
                if (!m_valid || rxack) begin
                    m_byte  = d_byte[d_rd];
                    m_valid = 1'b1;
                end else begin
                    m_ovr = 1'b1;
                end
                d_rd++;
            end else if (m_valid && rxack) begin
                m_valid = 1'b0;
            end
        end
    end

    initial forever begin
        @(negedge hwclk);
        if (!rst) begin
            m_busy = 1'b0;
            for (int i = 0; i < b_n; i++)
                if (cyc >= b_lo[i] && cyc <= b_hi[i]) m_busy = 1'b1;
            check("rxvalid", rxvalid, m_valid);
            check("rxbyte", rxbyte, m_byte);
            check("overrun", overrun, m_ovr);
            check("frame_err", frame_err, m_ferr);
            check("busy", busy, m_busy);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, want completion");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge hwclk);
            #1;
        end
    endtask

    task automatic wait_until(input int n);
        while (cyc < n) begin
            @(posedge hwclk);
            #1;
        end
    endtask

    task automatic drive(input bit sel, input logic v);
        if (sel) rx2 = v;
        else     rx1 = v;
    endtask

    task automatic ack();
        rxack = 1'b1;
        tick(1);
        rxack = 1'b0;
    endtask

    // Start bit falls now (cycle p); stop sample lands at p + 2 + c/2 + 9c.
    task automatic send(input bit sel, input logic [7:0] b, input bit stop_ok);
        int c;
        int ss;
        c  = sel ? C2 : C1;
        ss = cyc + 2 + c / 2 + 9 * c;
        if (!sel) begin
            b_lo[b_n] = cyc + 3;
            b_hi[b_n] = stop_ok ? ss : BIG;
            b_n++;
            if (stop_ok) begin
                d_cyc[d_wr]  = ss + 1;
                d_byte[d_wr] = b;
                d_wr++;
            end else begin
                f_cyc[f_wr] = ss + 1;
                f_wr++;
            end
        end
        drive(sel, 1'b0);
        tick(c);
        for (int k = 0; k < 8; k++) begin
            drive(sel, b[k]);
            tick(c);
        end
        drive(sel, stop_ok);
        if (stop_ok) tick(c);
    endtask

    initial begin
        int p;
        int r;
        int bi;

        tick(4);
        rst = 1'b0;
        tick(2);
        check("rst_rxbyte", rxbyte, 8'h00);
        check("rst_rxvalid", rxvalid, 0);
        check("rst_overrun", overrun, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_busy", busy, 0);

        // Glitch: 5 low cycles, rejected at the mid-start sample
        p = cyc;
        b_lo[b_n] = p + 3;
        b_hi[b_n] = p + 10;
        b_n++;
        rx1 = 1'b0;
        tick(5);
        rx1 = 1'b1;
        wait_until(p + 10);
        check("glitch_busy_hi", busy, 1);
        wait_until(p + 11);
        check("glitch_busy_lo", busy, 0);
        tick(30);
        check("glitch_rxvalid", rxvalid, 0);
        check("glitch_rxbyte", rxbyte, 8'h00);

        // Clean 0xA5, valid rises at T0+8+144+1 = p+155
        p = cyc;
        fork
            send(1'b0, 8'hA5, 1'b1);
            begin
                wait_until(p + 154);
                check("a5_early", rxvalid, 0);
                wait_until(p + 155);
                check("a5_valid", rxvalid, 1);
                check("a5_byte", rxbyte, 8'hA5);
            end
        join
        tick(20);
        check("a5_held", rxvalid, 1);
        ack();
        check("a5_acked", rxvalid, 0);

        // Framing error then break held for 20 bit times
        p  = cyc;
        bi = b_n;
        send(1'b0, 8'h00, 1'b0);
        wait_until(p + 154);
        check("ferr_early", frame_err, 0);
        wait_until(p + 155);
        check("ferr_pulse", frame_err, 1);
        wait_until(p + 156);
        check("ferr_end", frame_err, 0);
        check("ferr_rxvalid", rxvalid, 0);
        wait_until(p + 20 * C1);
        check("break_busy", busy, 1);
        r = cyc;
        b_hi[bi] = r + 2;
        rx1 = 1'b1;
        wait_until(r + 2);
        check("break_busy_last", busy, 1);
        wait_until(r + 3);
        check("break_idle", busy, 0);
        tick(20);
        send(1'b0, 8'h3C, 1'b1);
        tick(20);
        check("3c_byte", rxbyte, 8'h3C);
        check("3c_valid", rxvalid, 1);
        ack();

        // Ack coincides with delivery of 0x55 while 0x54 is pending
        send(1'b0, 8'h54, 1'b1);
        tick(20);
        check("54_byte", rxbyte, 8'h54);
        p = cyc;
        fork
            send(1'b0, 8'h55, 1'b1);
            begin
                wait_until(p + 154);
                rxack = 1'b1;
                wait_until(p + 155);
                rxack = 1'b0;
                check("55_byte", rxbyte, 8'h55);
                check("55_valid", rxvalid, 1);
                check("55_overrun", overrun, 0);
            end
        join
        tick(20);
        ack();

        // Overrun: back-to-back 0x31, 0x32 with no ack
        send(1'b0, 8'h31, 1'b1);
        send(1'b0, 8'h32, 1'b1);
        tick(20);
        check("ovr_byte", rxbyte, 8'h31);
        check("ovr_flag", overrun, 1);
        ack();
        check("ovr_acked", rxvalid, 0);
        send(1'b0, 8'h33, 1'b1);
        tick(20);
        check("33_byte", rxbyte, 8'h33);
        check("33_overrun", overrun, 1);
        ack();

        // Reset during data bit 4 of 0xFF
        p  = cyc;
        bi = b_n;
        fork
            send(1'b0, 8'hFF, 1'b1);
            begin
                wait_until(p + 2 + 8 + 5 * C1);
                #2;
                rst = 1'b1;
                b_hi[bi] = cyc;
                #1;
                check("arst_rxbyte", rxbyte, 8'h00);
                check("arst_rxvalid", rxvalid, 0);
                check("arst_overrun", overrun, 0);
                check("arst_busy", busy, 0);
                check("arst_frame_err", frame_err, 0);
                tick(2);
                rst = 1'b0;
            end
        join
        tick(10);
        send(1'b0, 8'h81, 1'b1);
        tick(20);
        check("81_byte", rxbyte, 8'h81);
        check("81_valid", rxvalid, 1);
        ack();

        // Full-rate timing: 0xA5 at T0+625+11250+1
        p = cyc;
        fork
            send(1'b1, 8'hA5, 1'b1);
            begin
                wait_until(p + 2 + 625 + 11250);
                check("slow_early", rxvalid2, 0);
                wait_until(p + 3 + 625 + 11250);
                check("slow_valid", rxvalid2, 1);
                check("slow_byte", rxbyte2, 8'hA5);
                check("slow_frame_err", frame_err2, 0);
            end
        join
        tick(5);
        check("slow_overrun", overrun2, 0);
        check("slow_busy", busy2, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart_rx_8n1.md
Name: uart_rx_8n1

Overview:
- UART 8N1 receiver that pairs with the lock's uart_tx_8n1 transmitter. Lets a host PC send key codes and commands into the digital lock.
- Runs directly on hwclk (12 MHz) with an internal baud counter. No derived clocks.
- Delivers each received byte through a holding register with a valid/ack handshake, plus framing-error and overrun status.

Parameters:
CLKS_PER_BIT, 1250, hwclk cycles per UART bit (12 MHz / 9600 baud); must be even and >= 4
HALF_BIT, CLKS_PER_BIT/2, cycles from the detected start edge to the mid-start-bit sample

Ports:
hwclk  input  1  system clock, 12 MHz
rst  input  1  asynchronous reset, active-high
rx  input  1  serial line, idle high, asynchronous to hwclk
rxbyte  output  8  last accepted byte
rxvalid  output  1  rxbyte holds an unacknowledged byte
rxack  input  1  consumer accepts rxbyte; qualified by rxvalid
frame_err  output  1  one-cycle pulse: stop bit sampled low
overrun  output  1  sticky: a byte was dropped because rxvalid was still set
busy  output  1  high in any state except IDLE

Behaviour:
- Reset (async, rst=1):
  - rxbyte=0x00, rxvalid=0, frame_err=0, overrun=0, busy=0.
  - Both synchronizer flops =1; state=IDLE; baud counter=0; bit index=0.
  - Reset mid-frame abandons the frame. No valid or error is reported for it.
- Input: rx passes through a 2-flop synchronizer (rx_s). All decisions use rx_s only.
- Timing reference: T0 = first cycle in IDLE with rx_s=0, which is the rx pin fall plus 2 cycles.
- State machine (IDLE, START, DATA, STOP, BREAK):
  - IDLE: if rx_s=0, go to START with counter=0.
  - START: counter increments. At counter=HALF_BIT-1 (cycle T0+HALF_BIT), sample rx_s.
    - If 0: go to DATA, counter=0, bit index=0.
    - If 1: glitch. Return to IDLE with no outputs.
  - DATA: counter wraps at CLKS_PER_BIT-1.
    - At each wrap, sample rx_s into the shift register MSB and shift right (data is LSB first). Bit index increments.
    - Bit k (k=0..7) is sampled at T0+HALF_BIT+(k+1)*CLKS_PER_BIT.
    - After bit 7, go to STOP with counter=0.
  - STOP: sample rx_s at counter=CLKS_PER_BIT-1, i.e. T0+HALF_BIT+9*CLKS_PER_BIT.
    - If 1: deliver the byte and return to IDLE in the next cycle, at mid-stop-bit, so a back-to-back start bit is caught.
    - If 0: frame_err pulses high for exactly one cycle, the byte is discarded, and the state goes to BREAK.
  - BREAK: wait until rx_s=1, then go to IDLE. A held-low line never produces a spurious frame.
- Delivery (registered): rxbyte and rxvalid update in the cycle after the stop sample, at T0+HALF_BIT+9*CLKS_PER_BIT+1.
  - If rxvalid=0, or rxvalid=1 and rxack=1 in the same cycle: load rxbyte, rxvalid=1, no overrun.
  - If rxvalid=1 and rxack=0: keep the old rxbyte, drop the new byte, set overrun=1.
- Handshake:
  - rxvalid=1 and rxack=1 clears rxvalid in the next cycle, unless a delivery coincides (rule above).
  - rxack while rxvalid=0 is ignored.
  - rxbyte is stable while rxvalid=1.
- overrun: sticky; cleared only by rst.
- frame_err: never asserted together with a delivery. Does not affect rxvalid or rxbyte.
- Counter widths: baud counter wide enough for CLKS_PER_BIT-1; bit index 3 bits.

Test Plan (CLKS_PER_BIT=16 unless noted):
1. Clean byte: send 0xA5 (idle 1, start, bits 1,0,1,0,0,1,0,1, stop) with rxack=0 -> rxvalid rises exactly at T0+8+144+1; rxbyte=0xA5; frame_err=0; overrun=0; rxvalid stays high until a 1-cycle rxack, then is low the next cycle.
2. Glitch rejection: drive rx low for 5 cycles, then high -> busy high briefly, returns to IDLE at T0+8; rxvalid, frame_err, rxbyte unchanged (0x00).
3. Framing/break: send 0x00 with stop bit low and hold rx low 20 bit times -> exactly one frame_err pulse at stop sample +1; rxvalid=0; busy stays high (BREAK) until rx returns high; a following 0x3C is then received correctly.
4. Overrun: send 0x31 then 0x32 back-to-back (one stop bit), no rxack -> rxbyte=0x31, overrun=1 after the second frame; ack, then send 0x33 -> rxbyte=0x33, overrun remains 1 until rst.
5. Simultaneous ack: assert rxack in the exact cycle 0x55 is delivered while 0x54 is pending -> rxbyte=0x55, rxvalid stays 1, overrun=0.
6. Reset mid-frame: assert rst during DATA bit 4 of 0xFF -> all outputs 0 immediately (async); after release, send 0x81 -> rxbyte=0x81. Repeat test 1 with CLKS_PER_BIT=1250 -> rxbyte=0xA5 at T0+625+11250+1.
